// File: rtl/fetch_pkg.sv
// Shared widths, reset value and address type for the LEGv8 fetch stage.
package fetch_pkg;

    localparam int PC_WIDTH = 64;
    localparam int PC_INC = 4;
    localparam logic [PC_WIDTH-1:0] RESET_PC = '0;

    typedef logic [PC_WIDTH-1:0] addr_t;

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program-counter register: synchronous active-low reset to a constant, load on enable.
module pc_reg #(
    parameter int W = fetch_pkg::PC_WIDTH,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC register, PC+PC_INC adder and branch mux.
// Optional FETCH_STALL_EN adds stall_F, which holds the PC and drops any branch.
module fetch_unit #(
    parameter int N = fetch_pkg::PC_WIDTH,
    parameter int PC_INC = fetch_pkg::PC_INC,
    parameter logic [N-1:0] RESET_PC = N'(fetch_pkg::RESET_PC)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         PCSrc_F,
    input  logic [N-1:0] PCBranch_F,
`ifdef FETCH_STALL_EN
    input  logic         stall_F,
`endif
    output logic [N-1:0] imem_addr_F
);

    logic [N-1:0] pc;
    logic [N-1:0] pc_plus;
    logic [N-1:0] next_pc;
    logic         pc_en;

    // Modulo-2^N increment: the top address simply wraps to zero.
    assign pc_plus = pc + N'(PC_INC);

    always_comb begin
        next_pc = pc_plus;
        if (PCSrc_F) begin
            next_pc = PCBranch_F;
        end
    end

`ifdef FETCH_STALL_EN
    assign pc_en = ~stall_F;
`else
    assign pc_en = 1'b1;
`endif

    pc_reg #(
        .W       (N),
        .RST_VAL (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (next_pc),
        .q     (pc)
    );

    assign imem_addr_F = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit; covers stall_F when FETCH_STALL_EN is defined.
module tb_fetch_unit;

    localparam int N = 64;

    logic         clk;
    logic         reset;
    logic         PCSrc_F;
    logic [N-1:0] PCBranch_F;
`ifdef FETCH_STALL_EN
    logic         stall_F;
`endif
    logic [N-1:0] imem_addr_F;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc_F     (PCSrc_F),
        .PCBranch_F  (PCBranch_F),
`ifdef FETCH_STALL_EN
        .stall_F     (stall_F),
`endif
        .imem_addr_F (imem_addr_F)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns past it before anyone samples.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pc(input string name, input logic [N-1:0] expected);
        checks++;
        if (imem_addr_F !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, imem_addr_F, expected);
        end else begin
            $display("ok   %s: 0x%016h", name, imem_addr_F);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        PCSrc_F = 1'b0;
        PCBranch_F = 64'hDEADBEEF_DEADBEEF;
        for (int i = 0; i < 3; i++) begin
            step();
            check_pc($sformatf("reset_edge%0d", i), 64'h0);
        end
    endtask

    task automatic test_sequential();
        reset = 1'b1;
        PCSrc_F = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            check_pc($sformatf("seq%0d", i), N'(4 * i));
        end
    endtask

    task automatic test_branch();
        PCSrc_F = 1'b1;
        PCBranch_F = 64'h1000;
        step();
        check_pc("branch_load", 64'h1000);
        PCSrc_F = 1'b0;
        step();
        check_pc("branch_next", 64'h1004);
    endtask

    task automatic test_reset_priority();
        reset = 1'b0;
        PCSrc_F = 1'b1;
        PCBranch_F = 64'h2000;
        #2;
        check_pc("reset_between_edges", 64'h1004);
        step();
        check_pc("reset_beats_branch", 64'h0);
        reset = 1'b1;
        step();
        check_pc("release_with_branch", 64'h2000);
        PCSrc_F = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        check_pc("release_sequential", 64'h4);
    endtask

    task automatic test_wrap();
        PCSrc_F = 1'b1;
        PCBranch_F = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        check_pc("wrap_load", 64'hFFFF_FFFF_FFFF_FFFC);
        PCSrc_F = 1'b0;
        step();
        check_pc("wrap_zero", 64'h0);
        step();
        check_pc("wrap_after", 64'h4);
    endtask

    task automatic test_unaligned_branch();
        PCSrc_F = 1'b1;
        PCBranch_F = 64'h0000_0000_1234_5677;
        step();
        check_pc("unaligned_load", 64'h0000_0000_1234_5677);
        PCSrc_F = 1'b0;
        step();
        check_pc("unaligned_next", 64'h0000_0000_1234_567B);
    endtask

`ifdef FETCH_STALL_EN
    task automatic test_stall();
        stall_F = 1'b0;
        PCSrc_F = 1'b1;
        PCBranch_F = 64'h8;
        step();
        check_pc("stall_setup", 64'h8);
        stall_F = 1'b1;
        PCBranch_F = 64'h3000;
        for (int i = 0; i < 2; i++) begin
            step();
            check_pc($sformatf("stall_hold%0d", i), 64'h8);
        end
        reset = 1'b0;
        step();
        check_pc("reset_beats_stall", 64'h0);
        reset = 1'b1;
        PCSrc_F = 1'b1;
        PCBranch_F = 64'h8;
        stall_F = 1'b0;
        step();
        check_pc("stall_resetup", 64'h8);
        stall_F = 1'b0;
        PCSrc_F = 1'b0;
        step();
        check_pc("stall_release", 64'hC);
    endtask
`endif

    initial begin
        reset = 1'b1;
        PCSrc_F = 1'b0;
        PCBranch_F = '0;
`ifdef FETCH_STALL_EN
        stall_F = 1'b0;
`endif
        #1;
        test_reset();
        test_sequential();
        test_branch();
        test_reset_priority();
        test_wrap();
        test_unaligned_branch();
`ifdef FETCH_STALL_EN
        test_stall();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
